// File: rtl/program_sequencer.sv
// program_sequencer: launches one of NUM_PROGRAMS table entries on the core and runs a req/ack handshake.
// Optional run watchdog enabled by defining SEQ_WATCHDOG_EN.  Rev 1.0
`default_nettype none

module program_sequencer #(
  parameter int PC_BITS      = 10,
  parameter int NUM_PROGRAMS = 4,
  parameter int CYCLE_BITS   = 16,
  parameter int MAX_CYCLES   = 50000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req,
  input  logic [$clog2(NUM_PROGRAMS)-1:0] prog_sel,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_PROGRAMS)-1:0] cfg_idx,
  input  logic [PC_BITS-1:0]              cfg_start,
  input  logic [PC_BITS-1:0]              cfg_done,
  input  logic [PC_BITS-1:0]              pc,
  output logic                            core_start,
  output logic [PC_BITS-1:0]              start_pc,
  output logic                            core_run,
  output logic                            busy,
  output logic                            ack,
  output logic                            timeout,
  output logic [CYCLE_BITS-1:0]           cycle_count
);

  localparam int SEL_BITS = $clog2(NUM_PROGRAMS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic [PC_BITS-1:0]    r_tbl_start [NUM_PROGRAMS];
  logic [PC_BITS-1:0]    r_tbl_done  [NUM_PROGRAMS];
  logic [PC_BITS-1:0]    r_start_pc;
  logic [PC_BITS-1:0]    r_run_done;
  logic [CYCLE_BITS-1:0] r_cycle_count;

  logic [SEL_BITS-1:0]   w_sel;
  logic                  w_cfg_ok;
  logic                  w_match;
  logic [CYCLE_BITS-1:0] w_count_inc;

  // Out-of-range selects fall back to entry 0; out-of-range writes are dropped.
  always_comb begin
    w_sel = prog_sel;
    if (32'(prog_sel) >= NUM_PROGRAMS) w_sel = '0;
  end

  assign w_cfg_ok    = (32'(cfg_idx) < NUM_PROGRAMS);
  assign w_match     = (pc == r_run_done);
  assign w_count_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CYCLE_BITS'(1);

`ifdef SEQ_WATCHDOG_EN
  logic r_timeout;
  logic w_wd_hit;

  assign w_wd_hit = (32'(w_count_inc) >= MAX_CYCLES);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (r_state == S_IDLE && req) begin
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN && !w_match && w_wd_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_max;
  assign w_unused_max = ^MAX_CYCLES;
  assign timeout      = 1'b0;
`endif

  // Table reads below see pre-write contents, so a same-cycle write never affects the launch.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROGRAMS; i++) begin
        r_tbl_start[i] <= '0;
        r_tbl_done[i]  <= '1;
      end
    end else if (cfg_we && w_cfg_ok) begin
      r_tbl_start[cfg_idx] <= cfg_start;
      r_tbl_done[cfg_idx]  <= cfg_done;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_start_pc    <= '0;
      r_run_done    <= '1;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_start_pc    <= r_tbl_start[w_sel];
            r_run_done    <= r_tbl_done[w_sel];
            r_cycle_count <= '0;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_RUN;
        S_RUN: begin
          r_cycle_count <= w_count_inc;
          if (w_match) begin
            r_state <= S_DONE;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (w_wd_hit) begin
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          if (!req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start  = (r_state == S_LAUNCH);
  assign core_run    = (r_state == S_RUN);
  assign busy        = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign ack         = (r_state == S_DONE);
  assign start_pc    = r_start_pc;
  assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: vector table, hand sequences and randomized runs against a run-level model.
`default_nettype none

module tb_program_sequencer;

  localparam int NP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [9:0]  cfg_start = '0;
  logic [9:0]  cfg_done = '0;
  logic [9:0]  pc = '0;
  logic        core_start;
  logic [9:0]  start_pc;
  logic        core_run;
  logic        busy;
  logic        ack;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] m_start [NP];
  logic [9:0] m_done  [NP];

  typedef struct {
    logic [1:0] idx;
    logic [9:0] st;
    logic [9:0] dn;
    int         cnt;
  } vec_t;
  vec_t vecs [4];

  program_sequencer #(
    .PC_BITS(10), .NUM_PROGRAMS(NP), .CYCLE_BITS(16), .MAX_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .prog_sel(prog_sel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_done(cfg_done),
    .pc(pc), .core_start(core_start), .start_pc(start_pc), .core_run(core_run),
    .busy(busy), .ack(ack), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic [9:0] s, input logic [9:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_start = s; cfg_done = d;
    step();
    cfg_we = 1'b0;
    m_start[i] = s; m_done[i] = d;
  endtask

  // Launch from IDLE; the core PC loads start on core_start and advances once per RUN cycle.
  task automatic do_run(input logic [1:0] sel, input logic [9:0] est, input int ecnt,
                        input bit wr, input logic [1:0] widx, input logic [9:0] wst,
                        input logic [9:0] wdn, input bit drop);
    int n;
    prog_sel = sel; req = 1'b1;
    if (wr) begin
      cfg_we = 1'b1; cfg_idx = widx; cfg_start = wst; cfg_done = wdn;
    end
    step();
    cfg_we = 1'b0;
    if (wr) begin
      m_start[widx] = wst; m_done[widx] = wdn;
    end
    chk("launch_core_start", 32'(core_start), 1);
    chk("launch_start_pc", 32'(start_pc), 32'(est));
    chk("launch_busy", 32'(busy), 1);
    chk("launch_count_clr", 32'(cycle_count), 0);
    pc = est;
    n = 0;
    forever begin
      step();
      if (ack) break;
      n++;
      chk("run_core_run", 32'(core_run), 1);
      chk("run_no_restart", 32'(core_start), 0);
      chk("run_count", 32'(cycle_count), 32'(n - 1));
      if (n > 50) begin
        chk("ack_wait_expired", 0, 1);
        break;
      end
      pc = est + 10'(n - 1);
    end
    chk("done_run_cycles", 32'(n), 32'(ecnt));
    chk("done_cycle_count", 32'(cycle_count), 32'(ecnt));
    chk("done_busy", 32'(busy), 0);
    chk("done_timeout", 32'(timeout), 0);
    chk("done_start_pc_hold", 32'(start_pc), 32'(est));
    if (drop) begin
      req = 1'b0;
      step();
      chk("ack_fall", 32'(ack), 0);
      chk("idle_count_hold", 32'(cycle_count), 32'(ecnt));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic [1:0] sel;
    logic [1:0] widx;
    logic [9:0] wst;
    logic [9:0] wdn;
    int ecnt;
    bit wr;

    vecs[0] = '{idx: 2'd2, st: 10'h010, dn: 10'h014, cnt: 5};
    vecs[1] = '{idx: 2'd3, st: 10'h100, dn: 10'h100, cnt: 1};
    vecs[2] = '{idx: 2'd1, st: 10'h3F0, dn: 10'h3F6, cnt: 7};
    vecs[3] = '{idx: 2'd0, st: 10'h000, dn: 10'h002, cnt: 3};
    for (int i = 0; i < NP; i++) begin
      m_start[i] = '0; m_done[i] = '1;
    end

    // Reset state
    reset = 1'b1;
    step(); step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_run", 32'(core_run), 0);
    chk("rst_cycle_count", 32'(cycle_count), 0);
    chk("rst_start_pc", 32'(start_pc), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Entry 0 from reset table: done address 0x3FF is never reached with pc held at 0
    prog_sel = 2'd0; req = 1'b1; pc = '0;
    step();
    chk("e0_core_start", 32'(core_start), 1);
    chk("e0_start_pc", 32'(start_pc), 0);
    req = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    n = 0;
    forever begin
      step();
      if (ack || n > 20) break;
      n++;
    end
    chk("wd_run_cycles", 32'(n), 8);
    chk("wd_ack", 32'(ack), 1);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_cycle_count", 32'(cycle_count), 8);
    step();
    chk("wd_ack_fall", 32'(ack), 0);
    chk("wd_timeout_hold", 32'(timeout), 1);
`else
    repeat (100) step();
    chk("long_core_run", 32'(core_run), 1);
    chk("long_busy", 32'(busy), 1);
    chk("long_ack", 32'(ack), 0);
    chk("long_cycle_count", 32'(cycle_count), 99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif

    // Table-driven runs
    for (int i = 0; i < 4; i++) begin
      cfg_write(vecs[i].idx, vecs[i].st, vecs[i].dn);
      do_run(vecs[i].idx, vecs[i].st, vecs[i].cnt, 1'b0, 2'd0, 10'd0, 10'd0, 1'b1);
    end

    // Hold req after ack: no relaunch, then drop and relaunch
    do_run(2'd2, 10'h010, 5, 1'b0, 2'd0, 10'd0, 10'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_ack", 32'(ack), 1);
      chk("hold_no_launch", 32'(core_start | busy), 0);
    end
    req = 1'b0;
    step();
    chk("hold_ack_fall", 32'(ack), 0);
    do_run(2'd2, 10'h010, 5, 1'b0, 2'd0, 10'd0, 10'd0, 1'b1);

    // Same-cycle write and launch of entry 1
    cfg_write(2'd1, 10'h020, 10'h022);
    do_run(2'd1, 10'h020, 3, 1'b1, 2'd1, 10'h040, 10'h045, 1'b1);
    do_run(2'd1, 10'h040, 6, 1'b0, 2'd0, 10'd0, 10'd0, 1'b1);

    // Reset during RUN cycle 3
    prog_sel = 2'd2; req = 1'b1;
    step();
    pc = 10'h010;
    step(); step();
    pc = 10'h011;
    step();
    pc = 10'h012;
    chk("mid_core_run", 32'(core_run), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_count", 32'(cycle_count), 0);
    chk("mid_rst_start_pc", 32'(start_pc), 0);
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_start[i] = '0; m_done[i] = '1;
    end
    step();
    chk("mid_idle_ack", 32'(ack), 0);
    // Table restored: entry 2 is (0, 0x3FF)
    prog_sel = 2'd2; req = 1'b1;
    step();
    chk("restored_start", 32'(start_pc), 0);
    pc = 10'h3FF;
    step(); step();
    chk("restored_done_ack", 32'(ack), 1);
    chk("restored_done_count", 32'(cycle_count), 1);
    req = 1'b0;
    step();

    // Randomized runs against the run-level model
    for (int i = 0; i < NP; i++) begin
      wst = 10'($urandom_range(0, 'h3F0));
      cfg_write(2'(i), wst, wst + 10'($urandom_range(0, 6)));
    end
    for (int it = 0; it < 25; it++) begin
      sel  = 2'($urandom_range(0, NP - 1));
      ecnt = int'(m_done[sel]) - int'(m_start[sel]) + 1;
      wr   = ($urandom_range(0, 2) == 0);
      widx = 2'($urandom_range(0, NP - 1));
      wst  = 10'($urandom_range(0, 'h3F0));
      wdn  = wst + 10'($urandom_range(0, 6));
      do_run(sel, m_start[sel], ecnt, wr, widx, wst, wdn, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("rnd_hold_ack", 32'(ack), 1);
      end
      req = 1'b0;
      step();
      chk("rnd_ack_fall", 32'(ack), 0);
      if ($urandom_range(0, 1) == 1) begin
        wst = 10'($urandom_range(0, 'h3F0));
        cfg_write(2'($urandom_range(0, NP - 1)), wst, wst + 10'($urandom_range(0, 6)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
